// File: rtl/clock_time_counter.sv
// Time-of-day counter (hh:mm:ss, BCD) with time-set mode.
// Every asynchronous input passes through its own synchronizer chain.
// Rising edges of the tick and the two buttons become one-cycle events.
// Counters are kept in BCD directly, so there is no conversion stage.
module clock_time_counter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hour_bcd,
  output logic       day_pulse
);

  localparam logic ST_RUN = 1'b0;
  localparam logic ST_SET = 1'b1;

  // Bit order: 0 = tick, 1 = set_mode, 2 = inc_min, 3 = inc_hour
  logic [3:0] async_in;
  logic [3:0] sync_last;

  assign async_in = {inc_hour, inc_min, set_mode, tick_1hz};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_reg;

      // Shift the raw input through SYNC_STAGES flops; the MSB is the usable copy
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) chain_reg <= '0;
        else        chain_reg <= {chain_reg[SYNC_STAGES-2:0], async_in[gi]};
      end

      assign sync_last[gi] = chain_reg[SYNC_STAGES-1];
    end
  endgenerate

  // One-cycle-delayed copies of the synchronized tick/button levels.
  // They reset to 0 so that an input held high across reset still yields an edge.
  logic [2:0] dly_reg;
  logic [2:0] edge_src;

  assign edge_src = {sync_last[3], sync_last[2], sync_last[0]};

  // Remember the previous synchronized level of each edge-detected input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dly_reg <= '0;
    else        dly_reg <= edge_src;
  end

  logic tick_ev, min_ev, hour_ev;
  assign tick_ev = edge_src[0] & ~dly_reg[0];
  assign min_ev  = edge_src[1] & ~dly_reg[1];
  assign hour_ev = edge_src[2] & ~dly_reg[2];

  // BCD increment, 00..59
  function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) return 8'h00;
      else                return {v[7:4] + 4'd1, 4'h0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // BCD increment, 00..23
  function automatic logic [7:0] bcd_inc24(input logic [7:0] v);
    if (v == 8'h23)     return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'h0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  logic       state_reg, state_next;
  logic [7:0] sec_reg, sec_next;
  logic [7:0] min_reg, min_next;
  logic [7:0] hour_reg, hour_next;
  logic       day_reg, day_next;

  // Mode follows the synchronized set_mode level in the same cycle it changes
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:  if (sync_last[1])  state_next = ST_SET;
      ST_SET:  if (!sync_last[1]) state_next = ST_RUN;
      default: state_next = ST_RUN;
    endcase
  end

  // Counter update; decisions use the next state so SET wins over a coincident tick
  always_comb begin
    sec_next  = sec_reg;
    min_next  = min_reg;
    hour_next = hour_reg;
    day_next  = 1'b0;
    if (state_next == ST_SET) begin
      sec_next = 8'h00;
      if (min_ev)  min_next  = bcd_inc60(min_reg);
      if (hour_ev) hour_next = bcd_inc24(hour_reg);
    end else if (tick_ev) begin
      sec_next = bcd_inc60(sec_reg);
      if (sec_reg == 8'h59) begin
        min_next = bcd_inc60(min_reg);
        if (min_reg == 8'h59) begin
          hour_next = bcd_inc24(hour_reg);
          if (hour_reg == 8'h23) day_next = 1'b1;
        end
      end
    end
  end

  // State and time registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      sec_reg   <= 8'h00;
      min_reg   <= 8'h00;
      hour_reg  <= 8'h00;
      day_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      sec_reg   <= sec_next;
      min_reg   <= min_next;
      hour_reg  <= hour_next;
      day_reg   <= day_next;
    end
  end

  assign sec_bcd   = sec_reg;
  assign min_bcd   = min_reg;
  assign hour_bcd  = hour_reg;
  assign day_pulse = day_reg;

endmodule
